// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed seven-segment scanner with refresh prescaler and anti-ghost blanking.
// Optional brightness PWM on the anodes is enabled by defining SEG7_DIMMING_EN.
module seg7_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 1000,
  parameter int BLANK_CYCLES     = 2,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
`ifdef SEG7_DIMMING_EN
  input  logic [3:0]            bright,
`endif
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_LIT  = PW'(BLANK_CYCLES);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_POL = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]    SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_POL     = (SEG_ACTIVE_LOW != 0);

  logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
  logic [NUM_DIGITS-1:0]      dpt_q, dpt_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0]      anode_q, anode_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic                       tick_q, tick_d;
  logic [3:0]                 cur_nib;
  logic                       cur_dp;
  logic [6:0]                 seg_log;
  logic                       lit;
`ifdef SEG7_DIMMING_EN
  logic [3:0]                 pwm_q, pwm_d;
`endif

  // Scan position: prescaler within a slot, digit index across slots.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (ena) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = 3'd0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    nib_d = nib_q;
    dpt_d = dpt_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && (wr_addr == 3'(i))) begin
        nib_d[i] = wr_data;
        dpt_d[i] = wr_dp;
      end
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib = nib_q[i];
        cur_dp  = dpt_q[i];
      end
    end
  end

  always_comb begin
    case (cur_nib)
      4'h0: seg_log = 7'h3F;
      4'h1: seg_log = 7'h06;
      4'h2: seg_log = 7'h5B;
      4'h3: seg_log = 7'h4F;
      4'h4: seg_log = 7'h66;
      4'h5: seg_log = 7'h6D;
      4'h6: seg_log = 7'h7D;
      4'h7: seg_log = 7'h07;
      4'h8: seg_log = 7'h7F;
      4'h9: seg_log = 7'h6F;
      4'hA: seg_log = 7'h77;
      4'hB: seg_log = 7'h7C;
      4'hC: seg_log = 7'h39;
      4'hD: seg_log = 7'h5E;
      4'hE: seg_log = 7'h79;
      default: seg_log = 7'h71;
    endcase
  end

  // Output stage sees the scan state one cycle late; blanking hides the index change.
  always_comb begin
    lit = ena && (presc_q >= PRESC_LIT);
`ifdef SEG7_DIMMING_EN
    pwm_d = pwm_q + 4'd1;
    lit   = lit && (pwm_q <= bright);
`endif
    anode_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = lit && (idx_q == 3'(i));
    end
    anode_d = anode_d ^ AN_POL;
    seg_d   = seg_log ^ SEG_POL;
    dp_d    = cur_dp ^ DP_POL;
    tick_d  = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nib_q   <= '0;
      dpt_q   <= '0;
      presc_q <= '0;
      idx_q   <= 3'd0;
      wrap_q  <= 1'b0;
      anode_q <= AN_POL;
      seg_q   <= SEG_POL;
      dp_q    <= DP_POL;
      tick_q  <= 1'b0;
`ifdef SEG7_DIMMING_EN
      pwm_q   <= 4'd0;
`endif
    end else begin
      nib_q   <= nib_d;
      dpt_q   <= dpt_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
`ifdef SEG7_DIMMING_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed steps then random traffic against a position-count model.
module tb_seg7_scan_mux;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n, ena, wr_en, wr_dp;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [N-1:0] anode;
  logic [6:0] seg;
  logic dp, frame_tick;
  logic [2:0] digit_idx;
`ifdef SEG7_DIMMING_EN
  logic [3:0] bright;
`endif

  int total = 0;
  int bad   = 0;

  // Model: absolute scan position plus the digit contents.
  int  m_pos;
  int  m_dig [N];
  int  m_dp  [N];
  bit  m_wrap;
  int  m_pwm;
  int  ft_seen;

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
                  .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp),
`ifdef SEG7_DIMMING_EN
    .bright(bright),
`endif
    .anode(anode), .seg(seg), .dp(dp), .digit_idx(digit_idx), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;  6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
     12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001; default: return 7'b1110001;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from pre-edge model state, advance model, compare after the edge.
  task automatic tick();
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp, e_ft;
    int pr, ix;
    bit on;
    pr = m_pos % R;
    ix = (m_pos / R) % N;
    on = ena && (pr >= B);
`ifdef SEG7_DIMMING_EN
    on = on && (m_pwm <= int'(bright));
`endif
    if (!rst_n) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      m_pos = 0; m_wrap = 0; m_pwm = 0;
      for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_dp[i] = 0; end
    end else begin
      e_an = '1;
      if (on) e_an[ix] = 1'b0;
      e_seg = ~hex7(m_dig[ix]);
      e_dp  = ~m_dp[ix][0];
      e_ft  = m_wrap;
      if (wr_en && wr_addr < N) begin
        m_dig[wr_addr] = wr_data;
        m_dp[wr_addr]  = wr_dp;
      end
      m_wrap = 0;
      if (ena) begin
        m_pos++;
        m_wrap = (m_pos % (N * R)) == 0;
      end
      m_pwm = (m_pwm + 1) % 16;
    end
    @(posedge clk);
    #1;
    check("anode", anode, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("frame_tick", frame_tick, e_ft);
    check("digit_idx", digit_idx, 3'((m_pos / R) % N));
    if (frame_tick) ft_seen++;
  endtask

  task automatic wr(int a, int d, int p);
    wr_en = 1; wr_addr = 3'(a); wr_data = 4'(d); wr_dp = p[0];
    tick();
    wr_en = 0;
  endtask

  initial begin
    rst_n = 0; ena = 1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0;
    m_pos = 0; m_wrap = 0; m_pwm = 0; ft_seen = 0;
    for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_dp[i] = 0; end
`ifdef SEG7_DIMMING_EN
    bright = 4'd15;
`endif
    @(negedge clk);
    tick(); tick();
    check("reset_anode", anode, 4'b1111);
    check("reset_seg", seg, 7'h7F);
    rst_n = 1;
    wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 1); wr(3, 4, 0);
    ft_seen = 0;
    for (int i = 0; i < 64; i++) tick();
    check("frame_count_64", ft_seen, 2);
    // Out-of-range address must be invisible.
    wr(5, 8, 1);
    for (int i = 0; i < 40; i++) tick();
    while ((m_pos % R) != 4) tick();
    ena = 0;
    tick();
    check("ena_off_anode", anode, 4'b1111);
    tick(); tick();
    ena = 1;
    for (int i = 0; i < 20; i++) tick();
    // Random traffic, including mid-scan resets and ena drops.
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      ena     = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
`ifdef SEG7_DIMMING_EN
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom_range(0, 15));
`endif
      tick();
    end
    rst_n = 1; wr_en = 0; ena = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
